// File: rtl/cordic_fsm_param.sv
// Sequencing controller for an iterative CORDIC datapath.
// Steps the datapath through N_ITER micro-rotations. Each rotation performs three
// add/sub handshakes (X, Y, Z) with the shared unit, and an add/sub wait longer
// than TIMEOUT cycles aborts the run with an error.
// Every output is registered from the decode of the cycle's state, so it appears
// on the cycle after that state was active.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   beg_FSM_CORDIC        start request (IDLE only)
//   ACK_FSM_CORDIC        consumer took the result / error
//   operation             00 cos, 01 sin, 10 atan, 11 magnitude
//   shift_region_flag     input-angle region, 01/10 = swapped
//   ready_add_subt        add/sub result valid
//   ready_CORDIC, busy, timeout_err            status to the requester
//   beg_add_subt, ack_add_subt                 add/sub handshake
//   mode, iter_idx, sel_mux_1, sel_mux_2, sel_out  datapath steering
//   enab_*                                     datapath register enables
module cordic_fsm_param #(
  parameter int unsigned N_ITER  = 24,
  parameter int unsigned ITER_W  = 5,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beg_FSM_CORDIC,
  input  logic              ACK_FSM_CORDIC,
  input  logic [1:0]        operation,
  input  logic [1:0]        shift_region_flag,
  input  logic              ready_add_subt,
  output logic              ready_CORDIC,
  output logic              busy,
  output logic              timeout_err,
  output logic              beg_add_subt,
  output logic              ack_add_subt,
  output logic              mode,
  output logic [ITER_W-1:0] iter_idx,
  output logic              sel_mux_1,
  output logic [1:0]        sel_mux_2,
  output logic [1:0]        sel_out,
  output logic              enab_RB1,
  output logic              enab_RB2,
  output logic              enab_d_ff_Xn,
  output logic              enab_d_ff_Yn,
  output logic              enab_d_ff_Zn,
  output logic              enab_dff_shifted,
  output logic              enab_dff_LUT_sign,
  output logic              enab_dff5,
  output logic              enab_d_ff_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_ADD, S_ACKS, S_POST, S_OUT, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [1:0]        var_q, var_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [1:0]        op_q, op_d, region_q, region_d;

  logic ready_q, ready_d, busy_q, busy_d, terr_q, terr_d;
  logic beg_as_q, beg_as_d, ack_as_q, ack_as_d, mode_q, mode_d;
  logic sel1_q, sel1_d;
  logic [1:0] sel2_q, sel2_d, selout_q, selout_d;
  logic rb1_q, rb1_d, rb2_q, rb2_d, xn_q, xn_d, yn_q, yn_d, zn_q, zn_d;
  logic shft_q, shft_d, lut_q, lut_d, dff5_q, dff5_d, dout_q, dout_d;

  // Region 01/10 means the datapath swapped X and Y for the input angle.
  logic swapped_c;
  assign swapped_c = shift_region_flag_swapped(region_q);

  function automatic logic shift_region_flag_swapped(input logic [1:0] rg);
    return rg[0] ^ rg[1];
  endfunction

  // Next-state, counter and output decode.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    var_d    = var_q;
    to_d     = to_q;
    op_d     = op_q;
    region_d = region_q;
    ready_d  = 1'b0;
    terr_d   = 1'b0;
    beg_as_d = 1'b0;
    ack_as_d = 1'b0;
    sel1_d   = sel1_q;
    sel2_d   = sel2_q;
    selout_d = selout_q;
    rb1_d    = 1'b0;
    rb2_d    = 1'b0;
    xn_d     = 1'b0;
    yn_d     = 1'b0;
    zn_d     = 1'b0;
    shft_d   = 1'b0;
    lut_d    = 1'b0;
    dff5_d   = 1'b0;
    dout_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (beg_FSM_CORDIC) begin
          rb1_d    = 1'b1;
          iter_d   = '0;
          var_d    = '0;
          to_d     = '0;
          op_d     = operation;
          region_d = shift_region_flag;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        rb2_d   = 1'b1;
        sel1_d  = (iter_q != '0);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shft_d  = 1'b1;
        lut_d   = 1'b1;
        var_d   = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        beg_as_d = 1'b1;
        sel2_d   = var_q;
        if (ready_add_subt) begin
          xn_d    = (var_q == 2'd0);
          yn_d    = (var_q == 2'd1);
          zn_d    = (var_q == 2'd2);
          to_d    = '0;
          state_d = S_ACKS;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          // This was the TIMEOUT-th consecutive cycle without a result.
          to_d    = '0;
          state_d = S_ERR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_ACKS: begin
        ack_as_d = 1'b1;
        if (var_q != 2'd2) begin
          var_d   = var_q + 2'd1;
          state_d = S_ADD;
        end else if (iter_q != ITER_W'(N_ITER - 1)) begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = S_LOAD;
        end else begin
          state_d = S_POST;
        end
      end
      S_POST: begin
        dff5_d = 1'b1;
        unique case (op_q)
          2'b00:   selout_d = swapped_c ? 2'b01 : 2'b00;
          2'b01:   selout_d = swapped_c ? 2'b00 : 2'b01;
          2'b10:   selout_d = 2'b10;
          default: selout_d = 2'b00;
        endcase
        state_d = S_OUT;
      end
      S_OUT: begin
        dout_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (ACK_FSM_CORDIC) state_d = S_IDLE;
        else                ready_d = 1'b1;
      end
      S_ERR: begin
        if (ACK_FSM_CORDIC) begin
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b1;
          terr_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    mode_d = op_d[1];
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      var_q    <= '0;
      to_q     <= '0;
      op_q     <= '0;
      region_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      beg_as_q <= 1'b0;
      ack_as_q <= 1'b0;
      mode_q   <= 1'b0;
      sel1_q   <= 1'b0;
      sel2_q   <= 2'b10;
      selout_q <= 2'b00;
      rb1_q    <= 1'b0;
      rb2_q    <= 1'b0;
      xn_q     <= 1'b0;
      yn_q     <= 1'b0;
      zn_q     <= 1'b0;
      shft_q   <= 1'b0;
      lut_q    <= 1'b0;
      dff5_q   <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      var_q    <= var_d;
      to_q     <= to_d;
      op_q     <= op_d;
      region_q <= region_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      beg_as_q <= beg_as_d;
      ack_as_q <= ack_as_d;
      mode_q   <= mode_d;
      sel1_q   <= sel1_d;
      sel2_q   <= sel2_d;
      selout_q <= selout_d;
      rb1_q    <= rb1_d;
      rb2_q    <= rb2_d;
      xn_q     <= xn_d;
      yn_q     <= yn_d;
      zn_q     <= zn_d;
      shft_q   <= shft_d;
      lut_q    <= lut_d;
      dff5_q   <= dff5_d;
      dout_q   <= dout_d;
    end
  end

  assign ready_CORDIC      = ready_q;
  assign busy              = busy_q;
  assign timeout_err       = terr_q;
  assign beg_add_subt      = beg_as_q;
  assign ack_add_subt      = ack_as_q;
  assign mode              = mode_q;
  assign iter_idx          = iter_q;
  assign sel_mux_1         = sel1_q;
  assign sel_mux_2         = sel2_q;
  assign sel_out           = selout_q;
  assign enab_RB1          = rb1_q;
  assign enab_RB2          = rb2_q;
  assign enab_d_ff_Xn      = xn_q;
  assign enab_d_ff_Yn      = yn_q;
  assign enab_d_ff_Zn      = zn_q;
  assign enab_dff_shifted  = shft_q;
  assign enab_dff_LUT_sign = lut_q;
  assign enab_dff5         = dff5_q;
  assign enab_d_ff_out     = dout_q;

endmodule

// File: tb/tb_cordic_fsm_param.sv
// Testbench for cordic_fsm_param (N_ITER=4, TIMEOUT=15): a timeline model builds the
// expected per-cycle output vector of each run, which is compared against the DUT.
module tb_cordic_fsm_param;
  localparam int NI = 4;
  localparam int IW = 5;
  localparam int TO = 15;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset, beg, ack_in, rdy_as;
  logic [1:0] operation, sreg;
  logic ready_CORDIC, busy, timeout_err, beg_add_subt, ack_add_subt, mode;
  logic [IW-1:0] iter_idx;
  logic sel_mux_1;
  logic [1:0] sel_mux_2, sel_out;
  logic enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn;
  logic enab_dff_shifted, enab_dff_LUT_sign, enab_dff5, enab_d_ff_out;

  cordic_fsm_param #(.N_ITER(NI), .ITER_W(IW), .TIMEOUT(TO), .TO_W(TW)) dut (
    .clk(clk), .reset(reset), .beg_FSM_CORDIC(beg), .ACK_FSM_CORDIC(ack_in),
    .operation(operation), .shift_region_flag(sreg), .ready_add_subt(rdy_as),
    .ready_CORDIC(ready_CORDIC), .busy(busy), .timeout_err(timeout_err),
    .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt), .mode(mode),
    .iter_idx(iter_idx), .sel_mux_1(sel_mux_1), .sel_mux_2(sel_mux_2), .sel_out(sel_out),
    .enab_RB1(enab_RB1), .enab_RB2(enab_RB2), .enab_d_ff_Xn(enab_d_ff_Xn),
    .enab_d_ff_Yn(enab_d_ff_Yn), .enab_d_ff_Zn(enab_d_ff_Zn),
    .enab_dff_shifted(enab_dff_shifted), .enab_dff_LUT_sign(enab_dff_LUT_sign),
    .enab_dff5(enab_dff5), .enab_d_ff_out(enab_d_ff_out));

  always #5 clk = ~clk;

  typedef struct packed {
    logic ready, busy, terr, beg_as, ack, mode;
    logic [IW-1:0] iter;
    logic sel1;
    logic [1:0] sel2, selout;
    logic rb1, rb2, xn, yn, zn, shft, lut, dff5, dout;
  } outv_t;

  // One expected output vector per cycle plus what the bench drives in that cycle.
  typedef struct {
    outv_t o;
    bit rdy;
    bit ack;
    bit beg;
  } rec_t;

  rec_t q[$];
  int n_chk = 0, n_fail = 0;
  int dly[3*NI];
  int last_acks, last_first_rdy;
  logic m_sel1, m_mode;
  logic [1:0] m_sel2, m_selout;
  logic [IW-1:0] m_iter;

  function automatic outv_t dut_out();
    outv_t o;
    o.ready = ready_CORDIC; o.busy = busy; o.terr = timeout_err;
    o.beg_as = beg_add_subt; o.ack = ack_add_subt; o.mode = mode;
    o.iter = iter_idx; o.sel1 = sel_mux_1; o.sel2 = sel_mux_2; o.selout = sel_out;
    o.rb1 = enab_RB1; o.rb2 = enab_RB2; o.xn = enab_d_ff_Xn; o.yn = enab_d_ff_Yn;
    o.zn = enab_d_ff_Zn; o.shft = enab_dff_shifted; o.lut = enab_dff_LUT_sign;
    o.dff5 = enab_dff5; o.dout = enab_d_ff_out;
    return o;
  endfunction

  function automatic outv_t reset_vec();
    outv_t o = '0;
    o.sel2 = 2'b10;
    return o;
  endfunction

  function automatic void model_reset();
    m_sel1 = 1'b0; m_sel2 = 2'b10; m_selout = 2'b00; m_mode = 1'b0; m_iter = '0;
  endfunction

  function automatic outv_t base(input bit bsy);
    outv_t o = '0;
    o.busy = bsy; o.mode = m_mode; o.iter = m_iter;
    o.sel1 = m_sel1; o.sel2 = m_sel2; o.selout = m_selout;
    return o;
  endfunction

  function automatic void push(input outv_t o);
    rec_t r;
    r.o = o; r.rdy = 1'b0; r.ack = 1'b0; r.beg = 1'b0;
    q.push_back(r);
  endfunction

  function automatic logic [1:0] exp_sel(input logic [1:0] op, input logic [1:0] rg);
    bit sw;
    sw = (rg == 2'b01) || (rg == 2'b10);
    case (op)
      2'b00:   return sw ? 2'b01 : 2'b00;
      2'b01:   return sw ? 2'b00 : 2'b01;
      2'b10:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Timeline of one run: each add/sub waits dly[] low cycles (>=TO means abort).
  function automatic void build(input logic [1:0] op, input logic [1:0] rg,
                                input int ack_wait, input bit ack_beg, input bit busy_beg);
    outv_t o;
    bit abort;
    abort = 1'b0;
    q.delete();
    m_mode = op[1];
    m_iter = '0;
    o = base(1); o.rb1 = 1; push(o);
    for (int i = 0; i < NI && !abort; i++) begin
      m_sel1 = (i != 0);
      o = base(1); o.rb2 = 1; push(o);
      o = base(1); o.shft = 1; o.lut = 1; push(o);
      for (int v = 0; v < 3 && !abort; v++) begin
        m_sel2 = 2'(v);
        if (dly[3*i+v] >= TO) begin
          repeat (TO) begin o = base(1); o.beg_as = 1; push(o); end
          abort = 1'b1;
        end else begin
          repeat (dly[3*i+v]) begin o = base(1); o.beg_as = 1; push(o); end
          q[q.size()-1].rdy = 1'b1;
          o = base(1); o.beg_as = 1; o.xn = (v == 0); o.yn = (v == 1); o.zn = (v == 2);
          push(o);
          if (v == 2 && i < NI-1) m_iter = IW'(i+1);
          o = base(1); o.ack = 1; push(o);
        end
      end
    end
    if (abort) begin
      repeat (ack_wait) begin o = base(1); o.ready = 1; o.terr = 1; push(o); end
    end else begin
      m_selout = exp_sel(op, rg);
      o = base(1); o.dff5 = 1; push(o);
      o = base(1); o.dout = 1; push(o);
      repeat (ack_wait) begin o = base(1); o.ready = 1; push(o); end
    end
    q[q.size()-1].ack = 1'b1;
    q[q.size()-1].beg = ack_beg;
    if (busy_beg) begin q[5].beg = 1'b1; q[6].beg = 1'b1; end
    repeat (3) push(base(0));
  endfunction

  task automatic chk(input string name, input int cyc, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one run from the model timeline, checking every cycle; abort_idx>=0 resets mid-run.
  task automatic run(input string name, input logic [1:0] op, input logic [1:0] rg,
                     input int abort_idx);
    outv_t a;
    int acks, first_rdy;
    acks = 0; first_rdy = -1;
    @(negedge clk);
    operation = op; sreg = rg; beg = 1'b1; rdy_as = 1'b0; ack_in = 1'b0;
    for (int c = 0; c < q.size(); c++) begin
      @(negedge clk);
      a = dut_out();
      chk(name, c, 64'(a), 64'(q[c].o));
      if (a.ack) acks++;
      if (a.ready && first_rdy < 0) first_rdy = c;
      operation = ~op; sreg = ~rg;
      if (c == abort_idx) begin
        reset = 1'b1; beg = 1'b0; rdy_as = 1'b0; ack_in = 1'b0;
        @(negedge clk);
        chk({name, "_reset"}, c+1, 64'(dut_out()), 64'(reset_vec()));
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk({name, "_after_reset"}, c+2, 64'(dut_out()), 64'(reset_vec()));
        return;
      end
      rdy_as = q[c].rdy; ack_in = q[c].ack; beg = q[c].beg;
    end
    last_acks = acks;
    last_first_rdy = first_rdy;
  endtask

  function automatic void zero_dly();
    for (int i = 0; i < 3*NI; i++) dly[i] = 0;
  endfunction

  initial begin
    int fr, na, k;
    logic [1:0] rop, rrg;
    reset = 1'b1; beg = 1'b0; ack_in = 1'b0; rdy_as = 1'b0; operation = '0; sreg = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 0, 64'(dut_out()), 64'(reset_vec()));
    reset = 1'b0;
    model_reset();

    // Immediate add/sub, cos region 00: pin the model with hand-derived numbers.
    zero_dly();
    build(2'b00, 2'b00, 3, 1'b0, 1'b0);
    fr = -1; na = 0; k = 0;
    for (int c = 0; c < q.size(); c++) begin
      if (q[c].o.ready && fr < 0) fr = c;
      if (q[c].o.ack) na++;
      if (q[c].o.rb2) begin
        chk("model_iter_seq", c, 64'(q[c].o.iter), 64'(k));
        k++;
      end
      if (q[c].o.dff5) chk("model_selout", c, 64'(q[c].o.selout), 64'(0));
    end
    chk("model_ready_cycle", 0, 64'(fr), 64'(35));
    chk("model_ack_count", 0, 64'(na), 64'(12));
    run("cos_r00", 2'b00, 2'b00, -1);
    chk("dut_ready_cycle", 0, 64'(last_first_rdy), 64'(35));
    chk("dut_ack_count", 0, 64'(last_acks), 64'(12));

    build(2'b01, 2'b10, 2, 1'b0, 1'b0);
    run("sin_r10", 2'b01, 2'b10, -1);
    build(2'b01, 2'b00, 2, 1'b0, 1'b0);
    run("sin_r00", 2'b01, 2'b00, -1);
    build(2'b10, 2'b01, 2, 1'b0, 1'b0);
    run("atan", 2'b10, 2'b01, -1);
    build(2'b11, 2'b11, 2, 1'b0, 1'b0);
    run("magnitude", 2'b11, 2'b11, -1);
    build(2'b00, 2'b01, 2, 1'b0, 1'b0);
    run("cos_r01", 2'b00, 2'b01, -1);

    // Add/sub stalls at iteration 2, Y update: abort, then a ready on the 15th cycle.
    zero_dly(); dly[7] = TO;
    build(2'b00, 2'b00, 2, 1'b0, 1'b0);
    run("timeout", 2'b00, 2'b00, -1);
    zero_dly(); dly[7] = TO-1;
    build(2'b01, 2'b01, 2, 1'b0, 1'b0);
    run("ready_15th", 2'b01, 2'b01, -1);

    // Random add/sub latencies with start pulses while busy.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3*NI; i++) dly[i] = int'($urandom_range(0, 10));
      rop = 2'($urandom_range(0, 3));
      rrg = 2'($urandom_range(0, 3));
      build(rop, rrg, 1 + int'($urandom_range(0, 3)), 1'b0, 1'b1);
      run("random", rop, rrg, -1);
    end

    // Reset during ADD and during DONE.
    zero_dly(); dly[0] = 6;
    build(2'b10, 2'b00, 2, 1'b0, 1'b0);
    run("reset_in_add", 2'b10, 2'b00, 5);
    zero_dly();
    build(2'b11, 2'b00, 4, 1'b0, 1'b0);
    run("reset_in_done", 2'b11, 2'b00, 36);

    // ACK and start together in DONE: back to IDLE without a new run.
    build(2'b01, 2'b10, 2, 1'b1, 1'b0);
    run("ack_with_beg", 2'b01, 2'b10, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_fsm_param.md
Name: cordic_fsm_param

Overview:
- Parametrised next-generation CORDIC sequencing controller.
- Integrates the iteration and variable counters and supports four operations: cos, sin, atan (vectoring) and magnitude (vectoring).
- Handshakes each X/Y/Z update with the shared add/subtract unit, with an ack pulse and a timeout.
- Sits between the CORDIC datapath (mux selects, register enables, shifter/LUT index) and the requesting module (start/ready/ACK).

Parameters:
- N_ITER, 24, number of CORDIC micro-rotations (>=2).
- ITER_W, 5, iteration index width; 2**ITER_W > N_ITER.
- TIMEOUT, 15, max consecutive ADD cycles without ready_add_subt before abort (>=1).
- TO_W, 4, timeout counter width; 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- beg_FSM_CORDIC  in  1  start request, sampled in IDLE only.
- ACK_FSM_CORDIC  in  1  consumer has taken the result.
- operation  in  2  00 cos, 01 sin, 10 atan, 11 magnitude.
- shift_region_flag  in  2  input-angle region (01/10 = swapped region).
- ready_add_subt  in  1  add/sub result valid.
- ready_CORDIC  out  1  result (or error) available, held until ACK.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  high with ready_CORDIC when the run was aborted.
- beg_add_subt  out  1  start add/sub, held throughout ADD.
- ack_add_subt  out  1  one-cycle pulse after the add/sub result is captured.
- mode  out  1  0 rotation (op 00/01), 1 vectoring (op 10/11).
- iter_idx  out  ITER_W  current iteration, drives shifter amount and LUT address.
- sel_mux_1  out  1  0 selects initial inputs when iter_idx==0, else 1 selects feedback.
- sel_mux_2  out  2  add/sub operand select: 00 X, 01 Y, 10 Z.
- sel_out  out  2  output select: 00 X, 01 Y, 10 Z.
- enab_RB1, enab_RB2  out  1 each  input register and post-mux register enables.
- enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn  out  1 each  iteration result register enables.
- enab_dff_shifted, enab_dff_LUT_sign  out  1 each  shifted X/Y register enable; LUT+sign register enable.
- enab_dff5, enab_d_ff_out  out  1 each  pre-sign-correction and output register enables.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, all counters 0, all outputs 0 except sel_mux_2=10.
- Reset mid-run aborts unconditionally; no ack_add_subt is issued.
- Latching: operation and shift_region_flag are latched on start; mode and sel_out derive from the latched copies.
- IDLE: when beg_FSM_CORDIC=1, pulse enab_RB1, clear iter/var/timeout counters, go to LOAD.
- LOAD (1 cycle): enab_RB2=1; sel_mux_1=(iter_idx!=0); go to SHIFT.
- SHIFT (1 cycle): enab_dff_shifted=1, enab_dff_LUT_sign=1; var=0; go to ADD.
- ADD:
  - beg_add_subt=1, sel_mux_2=var.
  - On ready_add_subt: pulse the enable for var (0→Xn, 1→Yn, 2→Zn), clear the timeout counter, go to ACKS.
  - Otherwise increment the timeout counter.
  - After TIMEOUT consecutive low cycles, go to ERR.
  - A ready on the TIMEOUT-th cycle is accepted.
- ACKS (1 cycle): ack_add_subt=1.
  - var<2: var++, go to ADD.
  - var==2 and iter_idx<N_ITER-1: iter_idx++, go to LOAD.
  - var==2 and iter_idx==N_ITER-1: go to POST.
- POST (1 cycle): enab_dff5=1 with sel_out set as follows.
  - cos: Y if region∈{01,10}, else X.
  - sin: X if region∈{01,10}, else Y.
  - atan: Z.
  - magnitude: X.
- OUT (1 cycle): enab_d_ff_out=1, sel_out held; go to DONE.
- DONE: ready_CORDIC=1 until ACK_FSM_CORDIC=1, then IDLE; ready is low the cycle after ACK.
- ERR: ready_CORDIC=1 and timeout_err=1 until ACK, then IDLE; no output register enables.
- beg_FSM_CORDIC while busy is ignored.
- beg_FSM_CORDIC and ACK_FSM_CORDIC in the same DONE cycle: return to IDLE; the start is not accepted.
- Latency with ready_add_subt immediate:
  - 8 cycles per iteration.
  - ready_CORDIC rises 8*N_ITER+3 cycles after the start-sampling edge.
- Counter width: iter_idx never exceeds N_ITER-1; no wrap occurs.

Test Plan:
- N_ITER=4, op=00, region=00, ready_add_subt tied 1, pulse start → ready_CORDIC high on cycle 35; exactly 12 ack_add_subt pulses; sel_out=00 at enab_dff5; iter_idx sequence 0,1,2,3.
- Same run with op=01, region=10 → sel_out=00 (X); with region=00 → sel_out=01 (Y); mode=0 throughout.
- op=10 → mode=1 throughout and sel_out=10; op=11 → sel_out=00; enable order Xn,Yn,Zn repeats each iteration.
- TIMEOUT=15, hold ready_add_subt low at iteration 2, var 1:
  - ERR after 15 ADD cycles; ready_CORDIC=1, timeout_err=1, no enab_d_ff_out.
  - ACK → IDLE, busy=0.
  - Repeat with ready on the 15th cycle → accepted, no error.
- Random add/sub delays 0–10 cycles → run completes; Zn never enabled before Yn within an iteration; beg_add_subt stays high until ready.
- Assert reset during ADD and during DONE → next cycle all outputs at reset values.
- Pulse beg during busy → ignored.
- ACK+beg in the same DONE cycle → IDLE with no new run.
